// File: rtl/ratio_mul_core.sv
// Ratio-scaling arithmetic core: restoring divider (IDLE/RUN FSM), serial-to-parallel
// shifter for the angle stream, and a sticky registered quotient*multi2 multiplier.
module ratio_mul_core #(
  parameter int DW = 26,
  parameter int VW = 14,
  parameter int SW = 10,
  parameter int MW = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DW-1:0]      dividend,
  input  logic [VW-1:0]      divisor,
  output logic [DW-1:0]      quotient,
  output logic               div_ok,
  input  logic               dext,
  output logic [SW-1:0]      dout,
  output logic               frame_ok,
  input  logic [MW-1:0]      multi2,
  output logic               mul_active,
  output logic [DW+MW-1:0]   product,
  output logic               dbg_state
);

  localparam int CW  = $clog2(DW);
  localparam int SCW = $clog2(SW);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              r_state;
  logic [DW-1:0]       r_dvd;
  logic [VW-1:0]       r_dvs;
  logic [VW:0]         r_rem;
  logic [DW-1:0]       r_qs;
  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_quotient;
  logic                r_div_ok;

  logic [SW-1:0]       r_dout;
  logic [SCW-1:0]      r_scnt;
  logic                r_frame_ok;

  logic                r_mul_active;
  logic [DW+MW-1:0]    r_product;

  logic [VW:0]         w_rem_sh;
  logic                w_qbit;
  logic [VW:0]         w_rem_next;
  logic                w_last;

  // The true shifted remainder is {r_rem, bit}; a set r_rem[VW] already exceeds any divisor.
  assign w_rem_sh   = {r_rem[VW-1:0], r_dvd[DW-1]};
  assign w_qbit     = r_rem[VW] | (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_next = w_qbit ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
  assign w_last     = (r_cnt == CW'(DW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_qs       <= '0;
      r_cnt      <= '0;
      r_quotient <= '0;
      r_div_ok   <= 1'b0;
    end else begin
      r_div_ok <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_rem   <= '0;
            r_qs    <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[DW-2:0], 1'b0};
            r_qs  <= {r_qs[DW-2:0], w_qbit};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_quotient <= {r_qs[DW-2:0], w_qbit};
              r_div_ok   <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= '0;
      r_scnt     <= '0;
      r_frame_ok <= 1'b0;
    end else begin
      r_frame_ok <= 1'b0;
      if (en) begin
        r_dout <= {r_dout[SW-2:0], dext};
        if (r_scnt == SCW'(SW - 1)) begin
          r_scnt     <= '0;
          r_frame_ok <= 1'b1;
        end else begin
          r_scnt <= r_scnt + 1'b1;
        end
      end
    end
  end

  // mul_active rises the edge after div_ok is seen, so the first product uses the fresh quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_active <= 1'b0;
      r_product    <= '0;
    end else begin
      if (r_div_ok) r_mul_active <= 1'b1;
      if (r_mul_active) begin
        r_product <= {{MW{1'b0}}, r_quotient} * {{DW{1'b0}}, multi2};
      end
    end
  end

  assign quotient   = r_quotient;
  assign div_ok     = r_div_ok;
  assign dout       = r_dout;
  assign frame_ok   = r_frame_ok;
  assign mul_active = r_mul_active;
  assign product    = r_product;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ratio_mul_core.sv
// Directed bench for ratio_mul_core: reset, division timing/boundaries, en gating,
// serial-to-parallel framing and the sticky multiplier.
module tb_ratio_mul_core;

  localparam int DW = 26;
  localparam int VW = 14;
  localparam int SW = 10;
  localparam int MW = 13;

  logic              clk;
  logic              rst;
  logic              en;
  logic [DW-1:0]     dividend;
  logic [VW-1:0]     divisor;
  logic [DW-1:0]     quotient;
  logic              div_ok;
  logic              dext;
  logic [SW-1:0]     dout;
  logic              frame_ok;
  logic [MW-1:0]     multi2;
  logic              mul_active;
  logic [DW+MW-1:0]  product;
  logic              dbg_state;

  int n_vec = 0;
  int n_err = 0;

  ratio_mul_core #(.DW(DW), .VW(VW), .SW(SW), .MW(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .div_ok     (div_ok),
    .dext       (dext),
    .dout       (dout),
    .frame_ok   (frame_ok),
    .multi2     (multi2),
    .mul_active (mul_active),
    .product    (product),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_div(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!div_ok && edges < 100);
  endtask

  task automatic run_div(input string tag, input logic [DW-1:0] dvd,
                         input logic [VW-1:0] dvs, input logic [DW-1:0] expq);
    int e;
    dividend = dvd;
    divisor  = dvs;
    en       = 1'b1;
    tick();
    wait_div(e);
    en = 1'b0;
    chk({tag, "_lat"}, 64'(e), 64'd26);
    chk({tag, "_q"}, 64'(quotient), 64'(expq));
  endtask

  initial begin
    int e;
    logic [SW-1:0] pat1;
    logic [SW-1:0] pat2;
    rst = 1'b1; en = 1'b0; dividend = '0; divisor = '0; dext = 1'b0; multi2 = '0;
    pat1 = 10'b1011001110;
    pat2 = 10'b0100110001;

    #3;
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_div_ok", 64'(div_ok), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_frame_ok", 64'(frame_ok), 64'd0);
    chk("rst_mul_active", 64'(mul_active), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk) rst = 1'b0;

    multi2 = 13'd4096;
    repeat (3) begin
      tick();
      chk("premul_product", 64'(product), 64'd0);
      chk("premul_active", 64'(mul_active), 64'd0);
    end

    // Reset during RUN step 10
    dext = 1'b1; dividend = 26'd16384000; divisor = 14'd3000; en = 1'b1;
    repeat (11) tick();
    chk("midrun_state", 64'(dbg_state), 64'd1);
    chk("midrun_dout", 64'(dout), 64'h3FF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", 64'(dout), 64'd0);
    chk("async_rst_state", 64'(dbg_state), 64'd0);
    chk("async_rst_quotient", 64'(quotient), 64'd0);
    chk("async_rst_product", 64'(product), 64'd0);
    en = 1'b0; dext = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();

    // 16384000 / 3000 = 5461 r 1000
    run_div("div_main", 26'd16384000, 14'd3000, 26'd5461);
    chk("div_ok_edge_active", 64'(mul_active), 64'd0);
    tick();
    chk("div_ok_pulse_end", 64'(div_ok), 64'd0);
    chk("mul_active_set", 64'(mul_active), 64'd1);
    chk("mul_first_hold", 64'(product), 64'd0);
    tick();
    chk("mul_4096", 64'(product), 64'd22368256);   // 5461*4096
    multi2 = 13'd8191;
    tick();
    chk("mul_8191", 64'(product), 64'd44731051);   // 5461*8191
    chk("quotient_hold", 64'(quotient), 64'd5461);

    run_div("div_max_by1", 26'h3FFFFFF, 14'd1, 26'h3FFFFFF);
    run_div("div_by0", 26'd12345, 14'd0, 26'h3FFFFFF);
    run_div("div_zero", 26'd0, 14'd3000, 26'd0);
    run_div("div_small", 26'd100, 14'd7, 26'd14);

    // Operand change after the load edge
    dividend = 26'd16384000; divisor = 14'd3000; en = 1'b1;
    tick();
    repeat (5) tick();
    dividend = 26'd123; divisor = 14'd7;
    wait_div(e);
    en = 1'b0;
    chk("opchg_lat", 64'(e + 5), 64'd26);
    chk("opchg_q", 64'(quotient), 64'd5461);

    // en gap of 5 cycles after step 8
    dividend = 26'd16384000; divisor = 14'd3000; en = 1'b1;
    tick();
    repeat (8) tick();
    en = 1'b0; dext = 1'b1;
    repeat (5) begin
      tick();
      chk("gap_dout", 64'(dout), 64'd0);
      chk("gap_div_ok", 64'(div_ok), 64'd0);
      chk("gap_state", 64'(dbg_state), 64'd1);
    end
    dext = 1'b0; en = 1'b1;
    wait_div(e);
    en = 1'b0;
    chk("gap_lat", 64'(8 + 5 + e), 64'd31);
    chk("gap_q", 64'(quotient), 64'd5461);

    // s2p framing from a clean reset
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst2_mul_active", 64'(mul_active), 64'd0);
    chk("rst2_product", 64'(product), 64'd0);
    en = 1'b1;
    for (int i = 0; i < SW; i++) begin
      dext = pat1[SW-1-i];
      tick();
      chk("frame1", 64'(frame_ok), 64'(i == SW - 1));
    end
    chk("s2p_word1", 64'(dout), 64'h2CE);
    for (int i = 0; i < SW; i++) begin
      dext = pat2[SW-1-i];
      tick();
      chk("frame2", 64'(frame_ok), 64'(i == SW - 1));
    end
    chk("s2p_word2", 64'(dout), 64'h131);
    en = 1'b0; dext = 1'b1;
    tick();
    chk("s2p_hold_dout", 64'(dout), 64'h131);
    chk("s2p_hold_frame", 64'(frame_ok), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
